apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter N_REQ, 2, number of requesters (2..8).
REQ-002 Parameter ADDR_W, 32, APB address width.
REQ-003 Parameter DATA_W, 32, APB data width.
REQ-004 Parameter TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (≥2).
REQ-005 PCLK  in  1  clock; all logic on rising edge.
REQ-006 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-007 req  in  N_REQ  per-requester transfer request, level; held until that requester's done or err.
REQ-008 req_write  in  N_REQ  per-requester direction, 1 = write.
REQ-009 req_addr  in  N_REQ×ADDR_W  per-requester address.
REQ-010 req_wdata  in  N_REQ×DATA_W  per-requester write data.
REQ-011 grant  out  N_REQ  one-hot owner of the current transfer; zero when idle.
REQ-012 done  out  N_REQ  one-cycle pulse, transfer completed OK.
REQ-013 err  out  N_REQ  one-cycle pulse, transfer aborted by timeout.
REQ-014 rdata  out  DATA_W  read data of last completed read; valid with done.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-016 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address and write data.
REQ-017 PRDATA  in  DATA_W; PREADY  in  1  APB slave response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-019 IDLE: if any req bit set, select winner round-robin, latch its write/addr/wdata into PWRITE/PADDR/PWDATA, set grant, go SETUP next cycle.
REQ-020 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable from SETUP through end of ACCESS.
REQ-022 ACCESS with PREADY=1 at a rising edge: transfer ends; the winner's done pulses the following cycle; for reads rdata takes PRDATA sampled at that edge.
REQ-023 On transfer end, if any req is pending (excluding the just-served bit), go directly to SETUP with the new winner (back-to-back, PSEL stays 1); otherwise go IDLE with PSEL=0, PENABLE=0, grant=0.
REQ-024 Minimum transfer latency: req high in IDLE -> done 3 cycles later when PREADY=1 on first ACCESS cycle.
REQ-025 Wait-state counter clears on ACCESS entry and increments each ACCESS cycle with PREADY=0; at TIMEOUT the transfer aborts, err pulses instead of done, rdata unchanged, then as REQ-023.
REQ-026 Round-robin: priority pointer moves to the index after the last granted requester; lowest index from pointer wins; pointer reset value 0.
REQ-027 A requester dropping req while granted is a protocol error; the transfer still completes normally.
REQ-028 done and err are never both high; at most one bit of done|err high per cycle.
REQ-029 req_addr/req_wdata changes after latch do not affect the current transfer.

Reset
REQ-030 PRESETn low: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, grant=0, done=0, err=0, rdata=0, pointer=0, counter=0, immediately and asynchronously.
REQ-031 Reset mid-transfer abandons it with no done/err; the first request after deassertion starts in IDLE.

Structure
REQ-032 Shared package apb_arb_pkg holds the state enum (IDLE/SETUP/ACCESS) and the default width/timeout constants.
REQ-033 One sub-module rr_arbiter (N_REQ requests, pointer in, one-hot grant out, combinational) performs the selection.

Verification
REQ-034 Single write, req[0], addr 0x10, wdata 0xA5A5_0001, PREADY=1 -> SETUP then ACCESS with PADDR 0x10, done[0] 3 cycles after req.
REQ-035 Read with 2 wait states, slave PRDATA 0xDEAD_BEEF -> ACCESS lasts 3 cycles, rdata 0xDEAD_BEEF with done.
REQ-036 req=2'b11 held continuously -> grants alternate 0,1,0,1, back-to-back with PSEL never dropping.
REQ-037 PREADY held 0, TIMEOUT=16 -> err pulse after 16 ACCESS cycles, no done, FSM returns to IDLE.
REQ-038 PRESETn asserted during ACCESS -> all outputs zero immediately; no done/err; a new request after release completes normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the arbitrated APB master.
// Holds the FSM state encoding and the default parameter values.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    localparam int unsigned DefNReq    = 2;
    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefTimeout = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: lowest set request at or after ptr wins,
// searching cyclically; grant is one-hot or zero.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by N_REQ requesters through a round-robin arbiter, with
// back-to-back transfers and a wait-state timeout that aborts with err.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = DefNReq,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int unsigned PtrW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   wait_q, wait_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic [N_REQ-1:0]  arb_req, arb_grant;
    logic [PtrW-1:0]   win;
    logic              load, end_xfer;

    // At transfer end the just-served requester is masked so others get a turn.
    assign arb_req = (state_q == StIdle) ? req : (req & ~grant_q);

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req  (arb_req),
        .ptr  (ptr_q),
        .grant(arb_grant)
    );

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) win = PtrW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wait_d   = wait_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        load     = 1'b0;
        end_xfer = 1'b0;

        case (state_q)
            StIdle: begin
                if (|req) load = 1'b1;
            end
            StSetup: begin
                state_d = StAccess;
                wait_d  = '0;
            end
            StAccess: begin
                if (PREADY) begin
                    end_xfer = 1'b1;
                    done_d   = grant_q;
                    if (!pwrite_q) rdata_d = PRDATA;
                end else if (wait_q == CntW'(TIMEOUT - 1)) begin
                    end_xfer = 1'b1;
                    err_d    = grant_q;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (end_xfer) begin
            if (|arb_req) begin
                load = 1'b1;
            end else begin
                state_d = StIdle;
                grant_d = '0;
            end
        end

        if (load) begin
            state_d  = StSetup;
            grant_d  = arb_grant;
            pwrite_d = req_write[win];
            paddr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
            pwdata_d = req_wdata[int'(win)*DATA_W +: DATA_W];
            ptr_d    = (win == PtrW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            wait_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wait_q   <= wait_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign PSEL    = (state_q != StIdle);
    assign PENABLE = (state_q == StAccess);
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: single write, wait-stated read,
// round-robin back-to-back, timeout abort and mid-transfer reset.
module tb_apb_arb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req, req_write, grant, done, err;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rdata, PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    apb_arb_master #(
        .N_REQ  (2),
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic sel, input logic en,
                             input logic [1:0] gnt, input logic [1:0] dn, input logic [1:0] er);
        check({tag, ".psel"}, 64'(PSEL), 64'(sel));
        check({tag, ".penable"}, 64'(PENABLE), 64'(en));
        check({tag, ".grant"}, 64'(grant), 64'(gnt));
        check({tag, ".done"}, 64'(done), 64'(dn));
        check({tag, ".err"}, 64'(err), 64'(er));
    endtask

    initial begin
        PRESETn   = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        #1;
        check_bus("rst", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check("rst.paddr", 64'(PADDR), 64'h0);
        check("rst.rdata", 64'(rdata), 64'h0);
        tick();
        tick();
        PRESETn = 1'b1;

        // Single write from requester 0, zero wait states
        req       = 2'b01;
        req_write = 2'b01;
        req_addr  = {32'h0, 32'h10};
        req_wdata = {32'h0, 32'hA5A5_0001};
        tick();
        check_bus("wr.setup", 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
        check("wr.paddr", 64'(PADDR), 64'h10);
        check("wr.pwdata", 64'(PWDATA), 64'hA5A5_0001);
        check("wr.pwrite", 64'(PWRITE), 64'h1);
        req_addr  = {32'h0, 32'h99};
        req_wdata = {32'h0, 32'h1234_5678};
        tick();
        check_bus("wr.access", 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
        check("wr.paddr_stable", 64'(PADDR), 64'h10);
        check("wr.pwdata_stable", 64'(PWDATA), 64'hA5A5_0001);
        tick();
        check_bus("wr.done", 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
        req = 2'b00;
        tick();
        check_bus("wr.idle", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

        // Read from requester 1 with two wait states
        PREADY    = 1'b0;
        req       = 2'b10;
        req_write = 2'b00;
        req_addr  = {32'h20, 32'h0};
        tick();
        check_bus("rd.setup", 1'b1, 1'b0, 2'b10, 2'b00, 2'b00);
        check("rd.pwrite", 64'(PWRITE), 64'h0);
        tick();
        check_bus("rd.acc1", 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
        tick();
        check_bus("rd.acc2", 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
        tick();
        check_bus("rd.acc3", 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
        check("rd.paddr", 64'(PADDR), 64'h20);
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        tick();
        check_bus("rd.done", 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
        check("rd.rdata", 64'(rdata), 64'hDEAD_BEEF);
        req    = 2'b00;
        PRDATA = 32'h0BAD_0BAD;
        tick();
        check("rd.rdata_hold", 64'(rdata), 64'hDEAD_BEEF);

        // Both requesting: grants alternate 0,1,0,1 back-to-back
        req       = 2'b11;
        req_write = 2'b11;
        req_addr  = {32'h200, 32'h100};
        req_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
        tick();
        for (int k = 0; k < 4; k++) begin
            check_bus($sformatf("rr%0d.setup", k), 1'b1, 1'b0, 2'(1 << (k % 2)),
                      (k == 0) ? 2'b00 : 2'(1 << ((k - 1) % 2)), 2'b00);
            check($sformatf("rr%0d.paddr", k), 64'(PADDR), (k % 2) ? 64'h200 : 64'h100);
            if (k == 3) req = 2'b10;
            tick();
            check_bus($sformatf("rr%0d.access", k), 1'b1, 1'b1, 2'(1 << (k % 2)), 2'b00, 2'b00);
            tick();
        end
        check_bus("rr.end", 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
        req = 2'b00;

        // Slave never ready: abort after 16 ACCESS cycles
        PREADY    = 1'b0;
        req       = 2'b01;
        req_write = 2'b00;
        tick();
        check_bus("to.setup", 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
        tick();
        check_bus("to.acc1", 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check_bus($sformatf("to.acc%0d", i), 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
        end
        tick();
        check_bus("to.err", 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        check("to.rdata", 64'(rdata), 64'hDEAD_BEEF);
        req = 2'b00;
        tick();
        check_bus("to.idle", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

        // Reset in the middle of an ACCESS
        req       = 2'b10;
        req_write = 2'b10;
        req_addr  = {32'h30, 32'h40};
        tick();
        check_bus("rs.setup", 1'b1, 1'b0, 2'b10, 2'b00, 2'b00);
        tick();
        check_bus("rs.access", 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
        #2;
        PRESETn = 1'b0;
        #1;
        check_bus("rs.async", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check("rs.paddr", 64'(PADDR), 64'h0);
        check("rs.pwrite", 64'(PWRITE), 64'h0);
        check("rs.rdata", 64'(rdata), 64'h0);
        req    = 2'b00;
        PREADY = 1'b1;
        tick();
        check_bus("rs.held", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        PRESETn   = 1'b1;
        req       = 2'b01;
        req_write = 2'b01;
        req_wdata = {32'h0, 32'h5555_AAAA};
        tick();
        check_bus("rs.new_setup", 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
        check("rs.new_paddr", 64'(PADDR), 64'h40);
        tick();
        check_bus("rs.new_access", 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
        tick();
        check_bus("rs.new_done", 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
        req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
